// File: rtl/med_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : med_ctrl_pkg
// Brief    : State encoding and window-derived constants for med_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package med_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CMP   = 3'd2,
        ST_EVICT = 3'd3,
        ST_DONE  = 3'd4
    } med_state_t;

    // Elimination passes needed to discard everything above the median.
    function automatic int med_passes(input int number);
        return (number - 1) / 2;
    endfunction

    // Compare cycles per pass: one per ring register feeding the max holder.
    function automatic int med_cmp_cycles(input int number);
        return number - 1;
    endfunction

    // Cycle index (from the first load cycle) in which the median is valid.
    function automatic int med_dso_cycle(input int number);
        return number + med_passes(number) * number + med_cmp_cycles(number);
    endfunction

endpackage : med_ctrl_pkg
`default_nettype wire

// File: rtl/med_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : med_ctrl
// Brief    : Load / compare / evict sequencer for the MED min/max median
//            datapath. Optional load-abort detection via MED_CTRL_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module med_ctrl
    import med_ctrl_pkg::*;
#(
    parameter int NUMBER = 9
) (
    input  logic CLK,
    input  logic nRST,
    input  logic DSI_IN,
    output logic DSI,
    output logic BYP,
    output logic DSO,
    output logic READY
`ifdef MED_CTRL_ERR_EN
    ,
    output logic ERR
`endif
);

    localparam int c_P    = med_passes(NUMBER);
    localparam int c_C    = med_cmp_cycles(NUMBER);
    localparam int CYC_W  = $clog2(NUMBER);
    localparam int PASS_W = $clog2(c_P + 1);

    localparam logic [CYC_W-1:0]  c_CYC_ONE       = CYC_W'(1);
    localparam logic [CYC_W-1:0]  c_CYC_LOAD_LAST = CYC_W'(NUMBER - 1);
    localparam logic [CYC_W-1:0]  c_CYC_CMP_LAST  = CYC_W'(c_C - 1);
    localparam logic [PASS_W-1:0] c_PASS_ONE      = PASS_W'(1);
    localparam logic [PASS_W-1:0] c_PASS_LAST     = PASS_W'(c_P);

    med_state_t        r_state;
    med_state_t        w_state_nxt;
    logic [CYC_W-1:0]  r_cyc;
    logic [CYC_W-1:0]  w_cyc_nxt;
    logic [PASS_W-1:0] r_pass;
    logic [PASS_W-1:0] w_pass_nxt;
    logic              w_err;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
            r_cyc   <= '0;
            r_pass  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_pass_nxt  = r_pass;
        DSI         = 1'b0;
        READY       = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                READY = 1'b1;
                DSI   = DSI_IN;
                if (DSI_IN) begin
                    // This cycle already shifts load sample 0.
                    w_state_nxt = ST_LOAD;
                    w_cyc_nxt   = c_CYC_ONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_LOAD: begin
                DSI = DSI_IN;
`ifdef MED_CTRL_ERR_EN
                if (!DSI_IN) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cyc_nxt   = '0;
                end else
`endif
                if (r_cyc == c_CYC_LOAD_LAST) begin
                    w_state_nxt = ST_CMP;
                    w_cyc_nxt   = '0;
                    w_pass_nxt  = '0;
                end else begin
                    w_cyc_nxt = r_cyc + c_CYC_ONE;
                end
            end

            ST_CMP: begin
                if (r_cyc == c_CYC_CMP_LAST) begin
                    w_cyc_nxt   = '0;
                    w_state_nxt = (r_pass < c_PASS_LAST) ? ST_EVICT : ST_DONE;
                end else begin
                    w_cyc_nxt = r_cyc + c_CYC_ONE;
                end
            end

            ST_EVICT: begin
                // One plain shift: R7 overwrites R8 and the current max is lost.
                w_state_nxt = ST_CMP;
                w_cyc_nxt   = '0;
                w_pass_nxt  = r_pass + c_PASS_ONE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cyc_nxt   = '0;
                w_pass_nxt  = '0;
            end
        endcase
    end

    assign BYP = (r_state == ST_CMP);
    assign DSO = (r_state == ST_DONE);

`ifdef MED_CTRL_ERR_EN
    assign ERR = w_err;
`else
    logic w_err_unused;
    assign w_err_unused = w_err;
`endif

endmodule : med_ctrl
`default_nettype wire

// File: doc/med_ctrl.md
# med_ctrl

Sequencing controller for the 9-register min/max median datapath (`MED`). It gates the pixel strobe into `MED` and loads a window of `NUMBER` samples. It then drives `BYP` through the elimination passes that discard the `(NUMBER-1)/2` largest values, and pulses `DSO` in the single cycle in which `MED.DO` holds the median. One instance sits beside each `MED` instance, between the pixel source and the median consumer.

## Interface
- `NUMBER`, default 9: window size; odd, ≥3; must equal `MED.number`.
- `CLK` input 1: single clock, rising edge.
- `nRST` input 1: reset, asynchronous, active-low.
- `DSI_IN` input 1: pixel-valid strobe from the source; `DI` goes to `MED` directly.
- `DSI` output 1: to `MED.DSI`; 1 = shift `DI` into R0.
- `BYP` output 1: to `MED.BYP`; 1 = R8 captures the max (compare), 0 = plain shift.
- `DSO` output 1: median valid on `MED.DO`, one-cycle pulse.
- `READY` output 1: controller accepts a new window start this cycle.
- `ERR` output 1: load-protocol error pulse. Present only with `MED_CTRL_ERR_EN`.

## Operation
- Definitions:
  - P = `(NUMBER-1)/2`.
  - C = `NUMBER-1`, the compare cycles per pass.
- States: IDLE, LOAD, CMP, EVICT, DONE.
- Counters:
  - `cyc`, 0..`NUMBER-1`, width `$clog2(NUMBER)`.
  - `pass`, 0..P, width `$clog2(P+1)`.
- IDLE / DONE:
  - `READY`=1, `BYP`=0.
  - `DSI` = `DSI_IN`.
  - `DSI_IN`=1 → LOAD, `cyc`=1. That cycle is load cycle 0.
- LOAD:
  - `DSI` = `DSI_IN`, `BYP`=0, `READY`=0.
  - When `cyc`=`NUMBER-1` → CMP, `pass`=0, `cyc`=0.
- CMP:
  - `DSI`=0, `BYP`=1.
  - After C cycles: if `pass`<P → EVICT; else → DONE.
- EVICT:
  - One cycle, `DSI`=0, `BYP`=0. R8 is overwritten by R7, dropping the current max.
  - Then → CMP with `pass`+1.
- DONE: `DSO`=1 for exactly this cycle. Otherwise behaves as IDLE; if `DSI_IN`=0 → IDLE.
- `DSI_IN` outside IDLE/LOAD/DONE is ignored; `DSI` is held 0.
- `BYP` and `DSO` are Moore outputs, decoded from registered state.
- `DSI` and `READY` are combinational from state and `DSI_IN`.
- Reset values: state IDLE, counters 0, `BYP`=0, `DSO`=0, `READY`=1, `ERR`=0. `DSI` is 0 while `DSI_IN`=0.
- Reset asserted mid-operation:
  - The controller returns to IDLE immediately.
  - No `DSO` is produced for the aborted window.
  - `MED` contents are stale; the next window fully overwrites them.

## Timing
- Cycle 0 is the first cycle with `DSI_IN`=1 in IDLE/DONE.
- Load: cycles 0..`NUMBER-1`.
- Pass p < P:
  - CMP at `NUMBER+p*NUMBER` .. `NUMBER+p*NUMBER+C-1`.
  - EVICT at `NUMBER+p*NUMBER+C`.
- Final CMP: C cycles.
- `DSO` cycle = `NUMBER + P*NUMBER + C`. For `NUMBER`=9 this is 53.
- Minimum window period equals the `DSO` cycle number (53). A new load may start in the `DSO` cycle.
- `MED.DO` is valid only in the `DSO` cycle; `MED` keeps rotating afterwards.
- The source must present `NUMBER` consecutive `DSI_IN` cycles per window.

## Configuration
- `MED_CTRL_ERR_EN` defined:
  - A `DSI_IN`=0 during LOAD aborts the window: → IDLE, `ERR`=1 for one cycle, no `DSO`.
  - In the abort cycle `DSI`=0; a restart is possible the following cycle.
- Macro undefined:
  - No `ERR` port.
  - LOAD lasts exactly `NUMBER` cycles regardless of `DSI_IN`. Gap cycles shift `MIN` into R0.
  - `DSO` is still produced on schedule; the result is undefined.

## Structure
- Package `med_ctrl_pkg`:
  - state enum `med_state_t`.
  - functions/constants for P, C and the `DSO` cycle number derived from `NUMBER`.
- Single module: one FSM plus two counters. No sub-module is natural; `MED` is instantiated only in the bench/top.

## Test plan
- Bench instantiates `med_ctrl` + `MED` (width 8).
- Load 1..9 on consecutive cycles → `DSO` high only at cycle 53, `DO`=5. `BYP`=1 in cycles 9..16, 0 at 17.
- Load 9,9,9,1,1,1,5,5,5 → `DO`=5 at cycle 53. Load 200,0,255,17,17,3,99,128,64 → `DO`=64.
- Second window `DSI_IN` rises in the `DSO` cycle (53) → second `DSO` at cycle 106 with the correct median.
- `nRST` pulsed low at cycle 20 → `BYP`=0 and `DSO`=0 asynchronously; no `DSO` follows. `READY`=1 after release.
- `DSI_IN` toggled during cycles 10..50 → `DSI` stays 0; median unaffected.
- With `MED_CTRL_ERR_EN`, `DSI_IN` low at load cycle 4 → `ERR` pulse at cycle 4, IDLE, no `DSO`. Without the macro, `DSO` still occurs at cycle 53.
